// File: rtl/array_2_access_ctrl_if.sv
// array_2_access_ctrl_if
//   Request/response bundle between a requester and array_2_access_ctrl.
//   master : requester side (drives write/read requests, consumes responses)
//   slave  : controller side
//   Signals: w_valid/w_ready/w_addr/w_mask/w_data   write request channel
//            r_valid/r_ready/r_addr                 read request channel
//            resp_valid/resp_ready/resp_data        read response channel
interface array_2_access_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 308,
  parameter int SEGS   = 4
);
  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [SEGS-1:0]   w_mask;
  logic [DATA_W-1:0] w_data;
  logic              r_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output w_valid, w_addr, w_mask, w_data,
    input  w_ready,
    output r_valid, r_addr,
    input  r_ready,
    input  resp_valid, resp_data,
    output resp_ready
  );

  modport slave (
    input  w_valid, w_addr, w_mask, w_data,
    output w_ready,
    input  r_valid, r_addr,
    output r_ready,
    output resp_valid, resp_data,
    input  resp_ready
  );
endinterface

// File: rtl/array_2_access_ctrl.sv
// array_2_access_ctrl
//   Front end for the 512x308 single-port, 4-segment-masked data array.
//   Merges independent read and write channels onto the one RW port.
//   Writes are posted into a small FIFO. A read whose address matches any
//   buffered write is held off until that write has drained. Read data comes
//   back on a valid/ready channel and is held stable under backpressure.
//   Optional feature macro: ARRAY_CTRL_FWD_EN -- a read hit whose youngest
//   matching entry is full-mask is answered from the buffer, not stalled.
// Ports:
//   clock, reset         sole clock, synchronous active-high reset
//   req (slave modport)  write / read / response channels
//   sram_en, sram_wmode  array port enable and write mode
//   sram_addr/wmask/wdata array address, segment mask, write data
//   sram_rdata           array read data, valid the cycle after a read
module array_2_access_ctrl #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 308,
  parameter int SEGS       = 4,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  array_2_access_ctrl_if.slave req,
  output logic                sram_en,
  output logic                sram_wmode,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [SEGS-1:0]     sram_wmask,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);
  localparam int IDX_W = $clog2(WBUF_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {OP_IDLE, OP_READ, OP_DRAIN} port_op_e;

  logic [ADDR_W-1:0] wb_addr [WBUF_DEPTH];
  logic [SEGS-1:0]   wb_mask [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data [WBUF_DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr, wb_count;
  logic [IDX_W-1:0] wr_idx, rd_idx, hit_idx, scan_idx;
  logic             wb_full, wb_empty;
  logic             hazard, fwd_hit, resp_free;
  logic             r_fire, w_fire, pop;
  port_op_e         port_op;

  logic              resp_valid_q, use_hold;
  logic [DATA_W-1:0] hold_data;

  assign wr_idx   = wr_ptr[IDX_W-1:0];
  assign rd_idx   = rd_ptr[IDX_W-1:0];
  assign wb_count = wr_ptr - rd_ptr;
  // Extra wrap bit: same index with differing wrap bit means full.
  assign wb_full  = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign wb_empty = (wr_ptr == rd_ptr);

  // Scan entries oldest to youngest; the last match is the youngest hit.
  always_comb begin
    hazard   = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      scan_idx = rd_idx + IDX_W'(k);
      if ((PTR_W'(k) < wb_count) && (wb_addr[scan_idx] == req.r_addr)) begin
        hazard  = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  always_comb begin
`ifdef ARRAY_CTRL_FWD_EN
    fwd_hit = hazard && (&wb_mask[hit_idx]);
`else
    fwd_hit = 1'b0;
`endif
  end

  assign resp_free   = !resp_valid_q || req.resp_ready;
  assign req.w_ready = !wb_full;
  assign req.r_ready = !wb_full && (!hazard || fwd_hit) && resp_free;
  assign w_fire      = req.w_valid && req.w_ready;
  assign r_fire      = req.r_valid && req.r_ready;

  // One array access per cycle: forced drain, then read, then idle drain.
  always_comb begin
    port_op = OP_IDLE;
    if (reset)
      port_op = OP_IDLE;
    else if (wb_full)
      port_op = OP_DRAIN;
    else if (r_fire && !fwd_hit)
      port_op = OP_READ;
    else if (!wb_empty)
      port_op = OP_DRAIN;
  end

  assign pop = (port_op == OP_DRAIN);

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = req.r_addr;
    sram_wmask = '0;
    sram_wdata = wb_data[rd_idx];
    if (port_op == OP_READ) begin
      sram_en = 1'b1;
    end else if (port_op == OP_DRAIN) begin
      // A zero-mask entry still pops, but leaves the array untouched.
      sram_en    = |wb_mask[rd_idx];
      sram_wmode = |wb_mask[rd_idx];
      sram_addr  = wb_addr[rd_idx];
      sram_wmask = wb_mask[rd_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (w_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_fire) begin
      wb_addr[wr_idx] <= req.w_addr;
      wb_mask[wr_idx] <= req.w_mask;
      wb_data[wr_idx] <= req.w_data;
    end
  end

  // use_hold selects the hold register once sram_rdata is no longer valid
  // (second cycle of a stalled response) or for a forwarded read.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      use_hold     <= 1'b0;
    end else if (r_fire) begin
      resp_valid_q <= 1'b1;
      use_hold     <= fwd_hit;
    end else if (resp_valid_q && req.resp_ready) begin
      resp_valid_q <= 1'b0;
    end else if (resp_valid_q && !use_hold) begin
      use_hold <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (r_fire && fwd_hit)
      hold_data <= wb_data[hit_idx];
    else if (resp_valid_q && !req.resp_ready && !use_hold)
      hold_data <= sram_rdata;
  end

  assign req.resp_valid = resp_valid_q;
  assign req.resp_data  = use_hold ? hold_data : sram_rdata;
endmodule
